// File: rtl/iob2axil.sv
// rtl/iob2axil.sv - IOb slave to AXI4-Lite master bridge, one outstanding transaction
module iob2axil #(
   parameter int ADDR_W      = 21,
   parameter int DATA_W      = 32,
   parameter int AXIL_ADDR_W = ADDR_W,
   parameter int AXIL_DATA_W = DATA_W
) (
   input  logic                   clk_i,
   input  logic                   cke_i,
   input  logic                   rst_i,
   input  logic                   iob_avalid_i,
   input  logic [ADDR_W-1:0]      iob_addr_i,
   input  logic [DATA_W-1:0]      iob_wdata_i,
   input  logic [DATA_W/8-1:0]    iob_wstrb_i,
   output logic                   iob_rvalid_o,
   output logic [DATA_W-1:0]      iob_rdata_o,
   output logic                   iob_ready_o,
   output logic [AXIL_ADDR_W-1:0] axil_awaddr_o,
   output logic [2:0]             axil_awprot_o,
   output logic                   axil_awvalid_o,
   input  logic                   axil_awready_i,
   output logic [DATA_W-1:0]      axil_wdata_o,
   output logic [DATA_W/8-1:0]    axil_wstrb_o,
   output logic                   axil_wvalid_o,
   input  logic                   axil_wready_i,
   input  logic [1:0]             axil_bresp_i,
   input  logic                   axil_bvalid_i,
   output logic                   axil_bready_o,
   output logic [AXIL_ADDR_W-1:0] axil_araddr_o,
   output logic [2:0]             axil_arprot_o,
   output logic                   axil_arvalid_o,
   input  logic                   axil_arready_i,
   input  logic [DATA_W-1:0]      axil_rdata_i,
   input  logic [1:0]             axil_rresp_i,
   input  logic                   axil_rvalid_i,
   output logic                   axil_rready_o,
   output logic                   err_o,
   input  logic                   err_clr_i
);

   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D} state_t;

   if (AXIL_DATA_W != DATA_W) begin : g_bad_data_w
      $error("iob2axil: AXIL_DATA_W must equal DATA_W");
   end

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic bready_q, bready_d, arvalid_q, arvalid_d;
   logic rready_q, rready_d, rvalid_q, rvalid_d;
   logic err_q, err_d;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = awvalid_q & axil_awready_i;
   assign w_hs  = wvalid_q & axil_wready_i;
   assign b_hs  = bready_q & axil_bvalid_i;
   assign ar_hs = arvalid_q & axil_arready_i;
   assign r_hs  = rready_q & axil_rvalid_i;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rvalid_d  = 1'b0;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (iob_avalid_i) begin
               addr_d  = iob_addr_i;
               wdata_d = iob_wdata_i;
               wstrb_d = iob_wstrb_i;
               if (|iob_wstrb_i) begin
                  state_d   = WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = RD_A;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR: begin
            // AW and W retire independently; B is only opened once both are in.
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               state_d  = WR_B;
               bready_d = 1'b1;
            end
         end
         WR_B: begin
            if (b_hs) begin
               bready_d = 1'b0;
               state_d  = IDLE;
            end
         end
         RD_A: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_D;
            end
         end
         RD_D: begin
            if (r_hs) begin
               rdata_d  = axil_rdata_i;
               rvalid_d = 1'b1;
               rready_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (err_clr_i) err_d = 1'b0;
      if ((b_hs && (axil_bresp_i != 2'b00)) || (r_hs && (axil_rresp_i != 2'b00))) err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else if (cke_i) begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
      end
   end

   logic [AXIL_ADDR_W-1:0] axil_addr;
   if (AXIL_ADDR_W > ADDR_W) begin : g_addr_ext
      assign axil_addr = {{(AXIL_ADDR_W-ADDR_W){1'b0}}, addr_q};
   end else begin : g_addr_trunc
      assign axil_addr = addr_q[AXIL_ADDR_W-1:0];
   end

   assign iob_ready_o    = (state_q == IDLE);
   assign iob_rvalid_o   = rvalid_q;
   assign iob_rdata_o    = rdata_q;
   assign axil_awaddr_o  = axil_addr;
   assign axil_araddr_o  = axil_addr;
   assign axil_awprot_o  = 3'b000;
   assign axil_arprot_o  = 3'b000;
   assign axil_awvalid_o = awvalid_q;
   assign axil_wdata_o   = wdata_q;
   assign axil_wstrb_o   = wstrb_q;
   assign axil_wvalid_o  = wvalid_q;
   assign axil_bready_o  = bready_q;
   assign axil_arvalid_o = arvalid_q;
   assign axil_rready_o  = rready_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_iob2axil.sv
// tb/tb_iob2axil.sv - directed self-checking bench for iob2axil
module tb_iob2axil;

   logic        clk = 1'b0;
   logic        cke, rst;
   logic        avalid;
   logic [20:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        ready_o;
   logic [20:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready;
   logic [31:0] axwdata, axrdata;
   logic [3:0]  axwstrb;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready;
   logic        err, err_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iob2axil dut (
      .clk_i(clk), .cke_i(cke), .rst_i(rst),
      .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
      .iob_rvalid_o(rvalid_o), .iob_rdata_o(rdata_o), .iob_ready_o(ready_o),
      .axil_awaddr_o(awaddr), .axil_awprot_o(awprot), .axil_awvalid_o(awvalid), .axil_awready_i(awready),
      .axil_wdata_o(axwdata), .axil_wstrb_o(axwstrb), .axil_wvalid_o(wvalid), .axil_wready_i(wready),
      .axil_bresp_i(bresp), .axil_bvalid_i(bvalid), .axil_bready_o(bready),
      .axil_araddr_o(araddr), .axil_arprot_o(arprot), .axil_arvalid_o(arvalid), .axil_arready_i(arready),
      .axil_rdata_i(axrdata), .axil_rresp_i(rresp), .axil_rvalid_i(rvalid), .axil_rready_o(rready),
      .err_o(err), .err_clr_i(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [20:0] a, input logic [31:0] d, input logic [3:0] s);
      avalid = 1'b1;
      addr   = a;
      wdata  = d;
      wstrb  = s;
   endtask

   initial begin
      cke = 1'b1; rst = 1'b1; avalid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; axrdata = '0; err_clr = 1'b0;
      step(); step();
      rst = 1'b0;
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
      check("rst_rvalid", 32'(rvalid_o), 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("prot", {26'd0, awprot, arprot}, 32'd0);

      // zero-wait write
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      req(21'h10, 32'hDEADBEEF, 4'hF);
      step(); avalid = 1'b0;
      check("w1_ready_t1", 32'(ready_o), 32'd0);
      check("w1_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
      check("w1_awaddr", 32'(awaddr), 32'h10);
      check("w1_wdata", axwdata, 32'hDEADBEEF);
      check("w1_wstrb", 32'(axwstrb), 32'hF);
      step();
      check("w1_t2", {29'd0, awvalid, wvalid, bready}, 32'd1);
      check("w1_ready_t2", 32'(ready_o), 32'd0);
      step();
      check("w1_t3_ready", 32'(ready_o), 32'd1);
      check("w1_t3_bready", 32'(bready), 32'd0);
      check("w1_no_rvalid", 32'(rvalid_o), 32'd0);
      check("w1_err", 32'(err), 32'd0);

      // skewed write, ends with SLVERR
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      req(21'h40, 32'h0000AAAA, 4'h3);
      step(); avalid = 1'b0;
      check("w2_c1", {30'd0, awvalid, wvalid}, 32'd3);
      awready = 1'b1;
      step(); awready = 1'b0;
      check("w2_c2", {29'd0, awvalid, wvalid, bready}, 32'd2);
      step();
      check("w2_c3", {29'd0, awvalid, wvalid, bready}, 32'd2);
      check("w2_wstrb", 32'(axwstrb), 32'h3);
      check("w2_wdata", axwdata, 32'h0000AAAA);
      wready = 1'b1;
      step(); wready = 1'b0;
      check("w2_c4", {29'd0, awvalid, wvalid, bready}, 32'd1);
      bvalid = 1'b1; bresp = 2'b10;
      step(); bvalid = 1'b0; bresp = 2'b00;
      check("w2_done_ready", 32'(ready_o), 32'd1);
      check("w2_err_set", 32'(err), 32'd1);

      // read with delayed rvalid, clean response keeps sticky error
      arready = 1'b1;
      req(21'h24, 32'd0, 4'h0);
      step(); avalid = 1'b0;
      check("r1_arvalid", 32'(arvalid), 32'd1);
      check("r1_araddr", 32'(araddr), 32'h24);
      check("r1_ready_low", 32'(ready_o), 32'd0);
      step();
      check("r1_rready", {30'd0, arvalid, rready}, 32'd1);
      step();
      check("r1_wait", {30'd0, rready, rvalid_o}, 32'd2);
      rvalid = 1'b1; axrdata = 32'h12345678; rresp = 2'b00;
      step(); rvalid = 1'b0;
      check("r1_rvalid", 32'(rvalid_o), 32'd1);
      check("r1_rdata", rdata_o, 32'h12345678);
      check("r1_ready_back", 32'(ready_o), 32'd1);
      check("r1_err_sticky", 32'(err), 32'd1);
      step();
      check("r1_pulse_end", 32'(rvalid_o), 32'd0);
      check("r1_rdata_hold", rdata_o, 32'h12345678);

      err_clr = 1'b1;
      step(); err_clr = 1'b0;
      check("err_cleared", 32'(err), 32'd0);

      // error read with simultaneous clear; also a stalled cycle with cke low
      err_clr = 1'b1; arready = 1'b0;
      req(21'h8, 32'd0, 4'h0);
      step(); avalid = 1'b0;
      arready = 1'b1; cke = 1'b0;
      step(); cke = 1'b1;
      check("cke_hold", {30'd0, arvalid, rready}, 32'd2);
      step();
      rvalid = 1'b1; rresp = 2'b10; axrdata = 32'hCAFEF00D;
      step(); rvalid = 1'b0; rresp = 2'b00; err_clr = 1'b0;
      check("r2_rvalid", 32'(rvalid_o), 32'd1);
      check("r2_rdata_on_err", rdata_o, 32'hCAFEF00D);
      check("r2_set_wins", 32'(err), 32'd1);

      // back-to-back read then write, avalid held
      arready = 1'b1; rvalid = 1'b1; axrdata = 32'h55AA55AA;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
      req(21'h30, 32'd0, 4'h0);
      step();
      check("bb_busy", 32'(ready_o), 32'd0);
      step();
      step();
      check("bb_rvalid", {30'd0, rvalid_o, ready_o}, 32'd3);
      check("bb_rdata", rdata_o, 32'h55AA55AA);
      req(21'h34, 32'h11223344, 4'hF);
      step(); avalid = 1'b0;
      check("bb_wr_started", {29'd0, awvalid, wvalid, rvalid_o}, 32'd6);
      check("bb_awaddr", 32'(awaddr), 32'h34);
      check("bb_wdata", axwdata, 32'h11223344);
      step();
      check("bb_bready", 32'(bready), 32'd1);
      step();
      check("bb_wr_done", 32'(ready_o), 32'd1);

      // reset in the middle of a write
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      req(21'h50, 32'h0BADF00D, 4'hF);
      step(); avalid = 1'b0;
      check("mr_awvalid", 32'(awvalid), 32'd1);
      rst = 1'b1;
      step(); rst = 1'b0;
      check("mr_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
      check("mr_ready", 32'(ready_o), 32'd1);
      check("mr_err", 32'(err), 32'd0);
      arready = 1'b1; rvalid = 1'b1; axrdata = 32'h0BADCAFE;
      req(21'h60, 32'd0, 4'h0);
      step(); avalid = 1'b0;
      step();
      step();
      check("mr_read_rvalid", 32'(rvalid_o), 32'd1);
      check("mr_read_rdata", rdata_o, 32'h0BADCAFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
